// File: rtl/easy_fifo_pkg.sv
// Shared types and helpers for the easy_fifo read-side burst gate.
package easy_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_HOLD  = 2'd2
  } burst_state_t;

  // Level counters need one extra bit so that "completely full" is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/easy_fifo_axis_skid.sv
// 2-entry registered AXIS skid; head register drives the output directly.
// Handshake: a beat moves on a port when valid and ready are both high at a rising clock edge.
module easy_fifo_axis_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         push;
  logic         pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      // New beat goes straight to the head when the head is free or leaving this cycle.
      if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
        head_q <= in_data;
      end else if (pop && (count_q == 2'd2)) begin
        head_q <= tail_q;
      end
      if (push && (count_q == 2'd1) && !pop) begin
        tail_q <= in_data;
      end
      if (push && !pop) begin
        count_q <= count_q + 2'd1;
      end else if (!push && pop) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/easy_fifo_axis_burst_gate.sv
// Gates FIFO output into fixed-length, gap-free AXIS bursts with tlast on the final beat.
// Optional partial-burst release on idle timeout is enabled by EASY_FIFO_BURST_TIMEOUT_EN.
module easy_fifo_axis_burst_gate
  import easy_fifo_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int HOLDOFF   = 2,
  parameter int TIMEOUT   = 64,
  localparam int CW       = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic [CW-1:0]     fifo_cnt,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic [15:0]       burst_count,
  output burst_state_t      state
);

  localparam int HW = $clog2(HOLDOFF + 1);

  if ((BURST_LEN < 1) || (BURST_LEN > DEPTH)) begin : g_bad_burst_len
    $error("BURST_LEN must be within 1..DEPTH");
  end
  if ((HOLDOFF < 1) || (TIMEOUT < 1)) begin : g_bad_timing
    $error("HOLDOFF and TIMEOUT must be at least 1");
  end

  burst_state_t  state_q, state_d;
  logic [CW-1:0] beat_rem_q, beat_rem_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0]   count_q, count_d;
  logic          skid_ready;
  logic          in_burst;
  logic          last_beat;
  logic          s_fire;

  assign in_burst      = (state_q == ST_BURST);
  assign last_beat     = (beat_rem_q == CW'(1));
  assign s_axis_tready = !rst && in_burst && skid_ready;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign busy          = in_burst;
  assign burst_count   = count_q;
  assign state         = state_q;

`ifdef EASY_FIFO_BURST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d    = state_q;
    beat_rem_d = beat_rem_q;
    hold_d     = hold_q;
    count_d    = count_q;
`ifdef EASY_FIFO_BURST_TIMEOUT_EN
    timer_d    = '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        hold_d = '0;
        if (fifo_cnt >= CW'(BURST_LEN)) begin
          beat_rem_d = CW'(BURST_LEN);
          state_d    = ST_BURST;
        end
`ifdef EASY_FIFO_BURST_TIMEOUT_EN
        else if (fifo_cnt != '0) begin
          // Partial level lingering too long: release whatever is there as a short burst.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            beat_rem_d = fifo_cnt;
            state_d    = ST_BURST;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
`endif
      end
      ST_BURST: begin
        if (s_fire) begin
          beat_rem_d = beat_rem_q - CW'(1);
          if (last_beat) begin
            count_d = count_q + 16'd1;
            hold_d  = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // fifo_cnt may still include words just read; wait it out before trusting it.
        if (hold_q == HW'(HOLDOFF - 1)) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_rem_q <= '0;
      hold_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_rem_q <= beat_rem_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
    end
  end

`ifdef EASY_FIFO_BURST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  easy_fifo_axis_skid #(
    .W(DWIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({last_beat, s_axis_tdata}),
    .in_valid  (s_axis_tvalid && in_burst && !rst),
    .in_ready  (skid_ready),
    .out_data  ({m_axis_tlast, m_axis_tdata}),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

endmodule
